// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: single-outstanding fetch from a zero-latency-accept memory,
// a one-entry instruction holding register with format decode, and branch/jump redirect handling.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [2:0]  instr_fmt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    HOLD
  } state_t;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_SB  = 3'd3,
    FMT_U   = 3'd4,
    FMT_UJ  = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] instr_q, instr_pc_q;
  fmt_t        fmt_q;
  logic        valid_q;
  logic        load_instr;
  logic        clr_valid;
  logic [31:0] redir_tgt;
  fmt_t        rdata_fmt;

  function automatic fmt_t decode_fmt(input logic [6:0] opcode);
    fmt_t f;
    case (opcode)
      7'b0110011:                                      f = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:  f = FMT_I;
      7'b0100011:                                      f = FMT_S;
      7'b1100011:                                      f = FMT_SB;
      7'b0110111, 7'b0010111:                          f = FMT_U;
      7'b1101111:                                      f = FMT_UJ;
      default:                                         f = FMT_ILL;
    endcase
    return f;
  endfunction

  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign rdata_fmt = decode_fmt(imem_rdata[6:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect seen while an access is still outstanding is parked in target_q; the
  // access completes against the old pc and its data is dropped before refetching.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    load_instr = 1'b0;
    clr_valid  = 1'b0;
    imem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          if (imem_ready) begin
            pc_d = redir_tgt;
          end else begin
            target_d = redir_tgt;
            state_d  = DISCARD;
          end
        end else if (imem_ready) begin
          load_instr = 1'b1;
          state_d    = HOLD;
        end
      end
      DISCARD: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          target_d = redir_tgt;
        end
        if (imem_ready) begin
          pc_d    = redirect_valid ? redir_tgt : target_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d      = redir_tgt;
          clr_valid = 1'b1;
          state_d   = FETCH;
        end else if (consume) begin
          pc_d      = pc_q + 32'd4;
          clr_valid = 1'b1;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      target_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      fmt_q      <= FMT_I;
      valid_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      target_q <= target_d;
      if (load_instr) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc_q;
        fmt_q      <= rdata_fmt;
        valid_q    <= 1'b1;
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_fmt   = fmt_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed stimulus pushes expected accesses and presented
// instructions into queues; a negedge monitor pops and compares them as the DUT produces them.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        consume;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [2:0]  instr_fmt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [2:0]  fmt;
  } exp_t;

  exp_t        exp_instr_q[$];
  logic [31:0] exp_req_q[$];
  exp_t        mon_e;
  logic [31:0] mon_a;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .consume        (consume),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_fmt      (instr_fmt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_access(input logic [31:0] addr);
    exp_req_q.push_back(addr);
  endtask

  task automatic expect_instr(input logic [31:0] word, input logic [31:0] pc, input logic [2:0] fmt);
    exp_t e;
    e.word = word;
    e.pc   = pc;
    e.fmt  = fmt;
    exp_instr_q.push_back(e);
  endtask

  // Monitor: every accepted access and every newly presented instruction must be expected.
  always @(negedge clk) begin
    if (imem_req === 1'b1 && imem_ready === 1'b1) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: got addr %h expected no access", imem_addr);
      end else begin
        mon_a = exp_req_q.pop_front();
        chk("access_addr", imem_addr, mon_a);
      end
    end
    if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got %h at pc %h expected none", instr, instr_pc);
      end else begin
        mon_e = exp_instr_q.pop_front();
        chk("instr_word", instr, mon_e.word);
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("instr_fmt", {29'd0, instr_fmt}, {29'd0, mon_e.fmt});
      end
    end
    prev_valid = instr_valid;
  end

  logic [31:0] tbl_word [6];
  logic [2:0]  tbl_fmt  [6];

  initial begin
    logic [31:0] pc;
    tbl_word[0] = 32'h0040_2083; tbl_fmt[0] = 3'd1;
    tbl_word[1] = 32'h0000_8067; tbl_fmt[1] = 3'd1;
    tbl_word[2] = 32'h0000_0073; tbl_fmt[2] = 3'd1;
    tbl_word[3] = 32'h0000_1117; tbl_fmt[3] = 3'd4;
    tbl_word[4] = 32'h0020_81B3; tbl_fmt[4] = 3'd0;
    tbl_word[5] = 32'h1234_5600; tbl_fmt[5] = 3'd7;

    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0070_0013;
    redirect_valid = 1'b0; redirect_pc = '0; consume = 1'b0;

    // Reset state and first fetch after release
    step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fmt", {29'd0, instr_fmt}, 32'd1);
    rst = 1'b0;
    expect_access(32'h0);
    expect_instr(32'h0070_0013, 32'h0, 3'd1);
    step();
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_fmt", {29'd0, instr_fmt}, 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);

    // Back-to-back consume: S then SB, valid every other cycle
    rst = 1'b1;
    step();
    rst = 1'b0; consume = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0023;
    expect_access(32'h0);
    expect_instr(32'h0000_0023, 32'h0, 3'd2);
    step();
    chk("tp_valid0", {31'd0, instr_valid}, 32'd0);
    step();
    chk("tp_valid1", {31'd0, instr_valid}, 32'd1);
    imem_rdata = 32'h0000_0063;
    expect_access(32'h4);
    expect_instr(32'h0000_0063, 32'h4, 3'd3);
    step();
    chk("tp_valid2", {31'd0, instr_valid}, 32'd0);
    chk("tp_addr4", imem_addr, 32'h4);
    step();
    chk("tp_valid3", {31'd0, instr_valid}, 32'd1);
    consume = 1'b0; imem_ready = 1'b0;

    // Redirect while access is stalled: old address held, data dropped
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    chk("disc_addr_a", imem_addr, 32'h0);
    step();
    chk("disc_addr_b", imem_addr, 32'h0);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
    expect_access(32'h0);
    step();
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h0000_0037;
    expect_access(32'h0000_0100);
    expect_instr(32'h0000_0037, 32'h0000_0100, 3'd4);
    step();
    imem_ready = 1'b0;

    // Redirect beats consume in HOLD
    redirect_valid = 1'b1; redirect_pc = 32'h40; consume = 1'b1;
    step();
    redirect_valid = 1'b0; consume = 1'b0;
    chk("prio_valid", {31'd0, instr_valid}, 32'd0);
    chk("prio_addr", imem_addr, 32'h40);

    // Redirect coinciding with ready in FETCH: data dropped, refetch at target
    redirect_valid = 1'b1; redirect_pc = 32'h82; imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    expect_access(32'h40);
    step();
    redirect_valid = 1'b0;
    chk("same_addr", imem_addr, 32'h80);
    chk("same_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h0000_006F;
    expect_access(32'h80);
    expect_instr(32'h0000_006F, 32'h80, 3'd5);
    step();
    imem_ready = 1'b0;

    // pc wrap and illegal opcode
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1; imem_rdata = 32'h0000_007F;
    expect_access(32'hFFFF_FFFC);
    expect_instr(32'h0000_007F, 32'hFFFF_FFFC, 3'd7);
    step();
    imem_ready = 1'b0; consume = 1'b1;
    step();
    consume = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_valid", {31'd0, instr_valid}, 32'd0);

    // Decode sweep with consume held, starting from pc 0
    pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      imem_ready = 1'b1; imem_rdata = tbl_word[i]; consume = 1'b1;
      expect_access(pc);
      expect_instr(tbl_word[i], pc, tbl_fmt[i]);
      step();
      imem_ready = 1'b0;
      step();
      pc = pc + 32'd4;
    end
    consume = 1'b0;
    chk("sweep_addr", imem_addr, 32'h18);

    // Reset during a pending fetch
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    step();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    for (int n = 0; n < 10 && (exp_req_q.size() != 0 || exp_instr_q.size() != 0); n++) begin
      step();
    end
    chk("pending_access", exp_req_q.size(), 32'd0);
    chk("pending_instr", exp_instr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 SHALL have port imem_ready, input, 1 bit: memory accepts the request and returns imem_rdata in the same cycle.
REQ-007 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch or jump redirect strobe.
REQ-009 SHALL have port redirect_pc, input, 32 bits: redirect target; bits [1:0] are ignored and treated as 0.
REQ-010 SHALL have port consume, input, 1 bit: downstream decode/immediate-generation accepts the held instruction.
REQ-011 SHALL have port instr, output, 32 bits: held instruction, fed to the immediate generator.
REQ-012 SHALL have port instr_pc, output, 32 bits: address of the held instruction.
REQ-013 SHALL have port instr_valid, output, 1 bit: instr, instr_pc and instr_fmt are valid.
REQ-014 SHALL have port instr_fmt, output, 3 bits, encoded R=0, I=1, S=2, SB=3, U=4, UJ=5, ILLEGAL=7.

Function
REQ-015 SHALL implement states IDLE, FETCH, DISCARD and HOLD.
REQ-016 SHALL drive imem_req=1 only in FETCH and DISCARD, and SHALL drive imem_addr = pc, the internal fetch pointer, in every state.
REQ-017 SHALL hold imem_req and imem_addr stable from request assertion until the cycle imem_ready=1.
REQ-018 SHALL move IDLE->FETCH unconditionally on the first edge with rst=0.
REQ-019 In FETCH with imem_ready=1 and no redirect, SHALL latch instr=imem_rdata, instr_pc=pc and instr_fmt, then go to HOLD; instr_valid=1 from the next cycle.
REQ-020 SHALL decode instr_fmt from imem_rdata[6:0]: 0110011->R; 0010011, 0000011, 1100111, 1110011->I; 0100011->S; 1100011->SB; 0110111, 0010111->U; 1101111->UJ; any other opcode->ILLEGAL.
REQ-021 In HOLD with consume=1, SHALL set pc=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), clear instr_valid and go to FETCH.
REQ-022 In HOLD with consume=0, SHALL keep instr, instr_pc, instr_fmt and instr_valid unchanged.
REQ-023 With redirect_valid=1 in HOLD, SHALL set pc={redirect_pc[31:2],2'b00}, clear instr_valid and go to FETCH; redirect SHALL take priority over a simultaneous consume.
REQ-024 With redirect_valid=1 in FETCH and imem_ready=0, SHALL store the target into pc-next, keep imem_addr at the old pc, and go to DISCARD.
REQ-025 In FETCH with redirect_valid=1 and imem_ready=1 in the same cycle, SHALL discard imem_rdata, load the redirect target and stay in FETCH.
REQ-026 In DISCARD, SHALL complete the outstanding access, discard the data when imem_ready=1, load the stored target into pc and go to FETCH.
REQ-027 A further redirect in DISCARD SHALL overwrite the stored target, with the last redirect winning.
REQ-028 SHALL never assert instr_valid for data returned by a discarded access.
REQ-029 Minimum throughput SHALL be one instruction per 2 cycles, with zero-wait memory and consume held at 1.

Reset
REQ-030 On an edge with rst=1 in any state, SHALL set state=IDLE, pc=RESET_PC, instr=32'h0000_0013, instr_pc=RESET_PC, instr_fmt=1 and instr_valid=0.
REQ-031 An access outstanding when reset is sampled SHALL be abandoned; imem_req=0 from the following cycle, and the first post-reset request SHALL use RESET_PC.

Verification
REQ-032 Bench SHALL cover: reset, release, imem_ready=1 always, imem_rdata=32'h0070_0013 -> imem_req high 1 cycle after release with addr 0; next cycle instr_valid=1, instr_fmt=1, instr_pc=0.
REQ-033 Bench SHALL cover: consume=1 every cycle, memory returning 0x00000023 then 0x00000063 -> instr_fmt 2 then 3, instr_pc 0 then 4, instr_valid toggling 1-of-2 cycles.
REQ-034 Bench SHALL cover: imem_ready=0 for 3 cycles while redirect_valid=1 with redirect_pc=32'h0000_0103 in the first of them -> imem_addr stays 0 until ready; that data is not presented; next request addr=32'h0000_0100.
REQ-035 Bench SHALL cover: in HOLD, redirect_valid=1 and consume=1 together with redirect_pc=32'h40 -> instr_valid=0 next cycle, then imem_addr=32'h40.
REQ-036 Bench SHALL cover: pc=32'hFFFF_FFFC, consume -> next imem_addr=0; opcode 7'b1111111 -> instr_fmt=7.
REQ-037 Bench SHALL cover: rst=1 for one cycle during a pending FETCH -> imem_req=0, instr_valid=0, instr=32'h13; the first request after release is at RESET_PC.
